// File: rtl/rtc_time_core.sv
// BCD timekeeping core: 1 Hz prescaler, calendar counters, register-file writer.
// Define RTC_CLOCK_HALT_EN to enable the clock-halt (CH) bit in sec[7].
module rtc_time_core #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned NUM_REGS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [3:0] set_addr,
    input  logic [7:0] set_data,
    output logic [3:0] addr,
    output logic [7:0] data_out,
    output logic       write_en,
    output logic       busy,
    output logic       sec_pulse
);

    localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(NUM_REGS - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state, state_nx;
    logic [2:0]  idx;
    logic [31:0] presc;
    logic [7:0]  sec, min, hour, day, date, month, year;
    logic [7:0]  sec_n, min_n, hour_n, day_n, date_n, month_n, year_n;
    logic [7:0]  sv, mlen;
    logic        ch, dirty, tick, set_ok, range_ok, leap;
    logic        sec_w, min_w, hour_w, date_w, month_w;
    logic        c_min, c_hour, c_day, c_month, c_year;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef RTC_CLOCK_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) ch <= 1'b0;
        else if (set_ok && set_addr == 4'd0) ch <= set_data[7];
    end
`else
    assign ch = 1'b0;
`endif

    assign tick = !ch && (presc == PRESC_LAST);

    // Bit 7 of a sec write is the CH flag, never part of the seconds value.
    always_comb begin
        sv = (set_addr == 4'd0) ? {1'b0, set_data[6:0]} : set_data;
        range_ok = 1'b0;
        unique case (1'b1)
            set_addr == 4'd0,
            set_addr == 4'd1: range_ok = sv <= 8'h59;
            set_addr == 4'd2: range_ok = sv <= 8'h23;
            set_addr == 4'd3: range_ok = sv >= 8'h01 && sv <= 8'h07;
            set_addr == 4'd4: range_ok = sv >= 8'h01 && sv <= 8'h31;
            set_addr == 4'd5: range_ok = sv >= 8'h01 && sv <= 8'h12;
            set_addr == 4'd6: range_ok = 1'b1;
            default:          range_ok = 1'b0;
        endcase
        set_ok = set_en && range_ok && sv[3:0] <= 4'd9 && sv[7:4] <= 4'd9;
    end

    // Leap in BCD: even tens need ones in {0,4,8}, odd tens need {2,6}.
    always_comb begin
        leap = year[4] ? (year[1:0] == 2'b10) : (year[1:0] == 2'b00);
        mlen = 8'h31;
        unique case (1'b1)
            month == 8'h02: mlen = leap ? 8'h29 : 8'h28;
            month == 8'h04,
            month == 8'h06,
            month == 8'h09,
            month == 8'h11: mlen = 8'h30;
            default:        mlen = 8'h31;
        endcase
        sec_w   = sec == 8'h59;
        min_w   = min == 8'h59;
        hour_w  = hour == 8'h23;
        date_w  = date >= mlen;
        month_w = month == 8'h12;
        c_min   = tick && sec_w;
        c_hour  = c_min && min_w;
        c_day   = c_hour && hour_w;
        c_month = c_day && date_w;
        c_year  = c_month && month_w;
        sec_n   = tick ? (sec_w ? 8'h00 : bcd_inc(sec)) : sec;
        min_n   = c_min ? (min_w ? 8'h00 : bcd_inc(min)) : min;
        hour_n  = c_hour ? (hour_w ? 8'h00 : bcd_inc(hour)) : hour;
        day_n   = c_day ? (day == 8'h07 ? 8'h01 : day + 8'h01) : day;
        date_n  = c_day ? (date_w ? 8'h01 : bcd_inc(date)) : date;
        month_n = c_month ? (month_w ? 8'h01 : bcd_inc(month)) : month;
        year_n  = c_year ? (year == 8'h99 ? 8'h00 : bcd_inc(year)) : year;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            sec_pulse <= 1'b0;
            sec       <= 8'h00;
            min       <= 8'h00;
            hour      <= 8'h00;
            day       <= 8'h01;
            date      <= 8'h01;
            month     <= 8'h01;
            year      <= 8'h00;
        end else begin
            sec_pulse <= tick;
            if (set_ok && set_addr == 4'd0) presc <= '0;
            else if (ch) presc <= presc;
            else if (tick) presc <= '0;
            else presc <= presc + 32'd1;
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
            day   <= day_n;
            date  <= date_n;
            month <= month_n;
            year  <= year_n;
            // A set overrides the ticked value of its own field only.
            if (set_ok) begin
                unique case (1'b1)
                    set_addr == 4'd0: sec   <= sv;
                    set_addr == 4'd1: min   <= sv;
                    set_addr == 4'd2: hour  <= sv;
                    set_addr == 4'd3: day   <= sv;
                    set_addr == 4'd4: date  <= sv;
                    set_addr == 4'd5: month <= sv;
                    default:          year  <= sv;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            dirty <= 1'b1;
        end else begin
            state <= state_nx;
            idx   <= (state == WRITE && idx != IDX_LAST) ? idx + 3'd1 : 3'd0;
            if (state == IDLE && dirty) dirty <= 1'b0;
            else if (tick || set_ok) dirty <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (dirty) state_nx = WRITE;
            WRITE:   if (idx == IDX_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        write_en = state == WRITE;
        busy     = state == WRITE;
        addr     = write_en ? {1'b0, idx} : 4'd0;
        data_out = 8'h00;
        if (write_en) begin
            unique case (idx)
                3'd0:    data_out = {ch, sec[6:0]};
                3'd1:    data_out = min;
                3'd2:    data_out = hour;
                3'd3:    data_out = day;
                3'd4:    data_out = date;
                3'd5:    data_out = month;
                3'd6:    data_out = year;
                default: data_out = 8'h00;
            endcase
        end
    end

endmodule
